// File: rtl/rv32i_wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter and its LU holding FIFO.
// Combinational helpers only; no state lives here.
package rv32i_wb_port_arbiter_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic                  RESET_ENABLE  = 1'b0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [REG_ADDR_W-1:0] REG_ADDR0     = '0;
    localparam logic [DATA_W-1:0]     ZERO_WORD     = '0;

    typedef logic [DATA_W-1:0]     data_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t waddr;
        data_bus_t wdata;
    } lu_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_FIFO,
        WB_BYPASS
    } wb_src_e;

    function automatic logic is_x0(input reg_addr_t addr);
        return addr == REG_ADDR0;
    endfunction

endpackage

// File: rtl/rv32i_wb_fifo.sv
// DEPTH-entry holding FIFO for long-latency results; one-cycle push/pop, full/empty from registered count.
// An address-match clear invalidates stale entries (including one pushed the same cycle) without freeing them.
module rv32i_wb_fifo
    import rv32i_wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   push_valid_i,
    input  logic [4:0]             push_waddr_i,
    input  logic [31:0]            push_wdata_i,
    input  logic                   pop_i,
    input  logic                   clr_en_i,
    input  logic [4:0]             clr_addr_i,
    output logic                   head_valid_o,
    output logic [4:0]             head_waddr_o,
    output logic [31:0]            head_wdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lu_entry_t              mem_q [DEPTH];
    logic      [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic      [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic      [CNT_W-1:0]  count_q, count_d;
    lu_entry_t              push_entry;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
        // A same-cycle pipeline write to this address makes the new result stale on arrival.
        push_entry.valid = push_valid_i && !(clr_en_i && (push_waddr_i == clr_addr_i));
        push_entry.waddr = push_waddr_i;
        push_entry.wdata = push_wdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_ENABLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_en_i && (mem_q[i].waddr == clr_addr_i)) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid_o = mem_q[rd_ptr_q].valid;
    assign head_waddr_o = mem_q[rd_ptr_q].waddr;
    assign head_wdata_o = mem_q[rd_ptr_q].wdata;
    assign count_o      = count_q;
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/rv32i_wb_port_arbiter.sv
// Shares the register-file write port: pipeline first, then buffered LU results, then LU bypass; rf_* one cycle later.
// lu_ready drops when the FIFO is full; a starved FIFO head forces a one-cycle pipeline stall to drain.
module rv32i_wb_port_arbiter
    import rv32i_wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_we,
    input  logic [4:0]             pipe_waddr,
    input  logic [31:0]            pipe_wdata,
    input  logic                   lu_valid,
    input  logic [4:0]             lu_waddr,
    input  logic [31:0]            lu_wdata,
    output logic                   lu_ready,
    output logic                   stall_pipe,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic [$clog2(DEPTH):0] buf_count
);

    localparam int              SC_W        = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [SC_W-1:0] STARVE_LAST = SC_W'(STARVE_LIMIT - 1);

    logic                   fifo_full, fifo_empty;
    logic                   head_valid;
    reg_addr_t              head_waddr;
    data_bus_t              head_wdata;
    logic [$clog2(DEPTH):0] fifo_count;

    wb_src_e                src;
    logic                   pipe_act, lu_hs, push, pop;
    logic                   starve_inc, starve_hit;

    logic                   stall_q, stall_d;
    logic [SC_W-1:0]        starve_q, starve_d;
    logic                   rf_we_q, rf_we_d;
    reg_addr_t              rf_waddr_q, rf_waddr_d;
    data_bus_t              rf_wdata_q, rf_wdata_d;

    assign lu_ready = !fifo_full && (rst != RESET_ENABLE);
    assign lu_hs    = lu_valid && lu_ready;

    always_comb begin
        pipe_act = pipe_we && !is_x0(pipe_waddr) && !stall_q;

        if (pipe_act) begin
            src = WB_PIPE;
        end else if (!fifo_empty) begin
            src = WB_FIFO;
        end else if (lu_hs) begin
            src = WB_BYPASS;
        end else begin
            src = WB_NONE;
        end
        pop  = (src == WB_FIFO);
        push = lu_hs && (src != WB_BYPASS);

        rf_we_d    = WRITE_DISABLE;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (src)
            WB_PIPE: begin
                rf_we_d    = WRITE_ENABLE;
                rf_waddr_d = pipe_waddr;
                rf_wdata_d = pipe_wdata;
            end
            WB_FIFO: begin
                if (head_valid) begin
                    rf_we_d    = WRITE_ENABLE;
                    rf_waddr_d = head_waddr;
                    rf_wdata_d = head_wdata;
                end
            end
            WB_BYPASS: begin
                if (!is_x0(lu_waddr)) begin
                    rf_we_d    = WRITE_ENABLE;
                    rf_waddr_d = lu_waddr;
                    rf_wdata_d = lu_wdata;
                end
            end
            default: ;
        endcase

        // Squashed heads do not count as starving: nothing useful is waiting behind the pipeline.
        starve_inc = pipe_act && !fifo_empty && head_valid;
        starve_hit = starve_inc && (starve_q == STARVE_LAST);
        stall_d    = starve_hit;
        if (pop || fifo_empty || starve_hit) begin
            starve_d = '0;
        end else if (starve_inc) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    rv32i_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_valid_i (!is_x0(lu_waddr)),
        .push_waddr_i (lu_waddr),
        .push_wdata_i (lu_wdata),
        .pop_i        (pop),
        .clr_en_i     (pipe_act),
        .clr_addr_i   (pipe_waddr),
        .head_valid_o (head_valid),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_ENABLE) begin
            stall_q    <= 1'b0;
            starve_q   <= '0;
            rf_we_q    <= WRITE_DISABLE;
            rf_waddr_q <= REG_ADDR0;
            rf_wdata_q <= ZERO_WORD;
        end else begin
            stall_q    <= stall_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign stall_pipe = stall_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign buf_count  = fifo_count;

endmodule

// File: tb/tb_rv32i_wb_port_arbiter.sv
// Random and directed stimulus against a queue-based model of the write-port arbiter.
module tb_rv32i_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  buf_count;

    rv32i_wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .lu_ready   (lu_ready),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic        m_stall;
    logic        m_rf_we;
    logic [4:0]  m_rf_waddr;
    logic [31:0] m_rf_wdata;

    int n_cmp;
    int n_err;
    bit chk_en;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve   = 0;
        m_stall    = 1'b0;
        m_rf_we    = 1'b0;
        m_rf_waddr = '0;
        m_rf_wdata = '0;
    endtask

    // One clock of arbitration, evaluated from the rules on a plain queue.
    task automatic model_step();
        bit          pact, hs, empty, bypass, inc, trig, popped, wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        ent_t        e;
        if (rst == 1'b0) begin
            model_reset();
            return;
        end
        pact   = pipe_we && (pipe_waddr != 5'd0) && !m_stall;
        hs     = lu_valid && (mq.size() < DEPTH);
        empty  = (mq.size() == 0);
        inc    = pact && !empty && (mq[0].valid == 1'b1);
        wr     = 1'b0;
        bypass = 1'b0;
        popped = 1'b0;
        wa     = '0;
        wd     = '0;
        if (pact) begin
            wr = 1'b1; wa = pipe_waddr; wd = pipe_wdata;
        end else if (!empty) begin
            e      = mq.pop_front();
            popped = 1'b1;
            if (e.valid) begin
                wr = 1'b1; wa = e.addr; wd = e.data;
            end
        end else if (hs) begin
            bypass = 1'b1;
            if (lu_waddr != 5'd0) begin
                wr = 1'b1; wa = lu_waddr; wd = lu_wdata;
            end
        end
        if (hs && !bypass) begin
            mq.push_back('{(lu_waddr != 5'd0), lu_waddr, lu_wdata});
        end
        if (pact) begin
            foreach (mq[i]) begin
                if (mq[i].addr == pipe_waddr) mq[i].valid = 1'b0;
            end
        end
        trig    = inc && (m_starve == LIMIT - 1);
        m_stall = trig;
        if (popped || empty || trig) m_starve = 0;
        else if (inc)                m_starve++;
        m_rf_we = wr;
        if (wr) begin
            m_rf_waddr = wa;
            m_rf_wdata = wd;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rf_we",      32'(rf_we),      32'(m_rf_we));
            cmp("rf_waddr",   32'(rf_waddr),   32'(m_rf_waddr));
            cmp("rf_wdata",   rf_wdata,        m_rf_wdata);
            cmp("stall_pipe", 32'(stall_pipe), 32'(m_stall));
            cmp("lu_ready",   32'(lu_ready),   32'((rst == 1'b1) && (mq.size() < DEPTH)));
            cmp("buf_count",  32'(buf_count),  32'(mq.size()));
        end
    end

    task automatic set_in(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                          input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    task automatic rand_in(input int busy);
        set_in($urandom_range(0, 99) < busy, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        model_reset();
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            rand_in(70);
            tick();
        end
        cmp("lit_rst_rf_we",     32'(rf_we),      32'd0);
        cmp("lit_rst_rf_waddr",  32'(rf_waddr),   32'd0);
        cmp("lit_rst_rf_wdata",  rf_wdata,        32'd0);
        cmp("lit_rst_stall",     32'(stall_pipe), 32'd0);
        cmp("lit_rst_lu_ready",  32'(lu_ready),   32'd0);
        cmp("lit_rst_buf_count", 32'(buf_count),  32'd0);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();

        // Bypass
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        tick();
        cmp("lit_byp_rf_we",     32'(rf_we),     32'd1);
        cmp("lit_byp_rf_waddr",  32'(rf_waddr),  32'd5);
        cmp("lit_byp_rf_wdata",  rf_wdata,       32'h1234);
        cmp("lit_byp_buf_count", 32'(buf_count), 32'd0);

        // Conflict
        set_in(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        tick();
        cmp("lit_cfl1_rf_waddr", 32'(rf_waddr),  32'd3);
        cmp("lit_cfl1_rf_wdata", rf_wdata,       32'hA);
        cmp("lit_cfl1_count",    32'(buf_count), 32'd1);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        cmp("lit_cfl2_rf_we",    32'(rf_we),     32'd1);
        cmp("lit_cfl2_rf_waddr", 32'(rf_waddr),  32'd7);
        cmp("lit_cfl2_rf_wdata", rf_wdata,       32'hB);
        cmp("lit_cfl2_count",    32'(buf_count), 32'd0);

        // Squash
        set_in(1'b1, 5'd1, 32'h55, 1'b1, 5'd9, 32'h1);
        tick();
        set_in(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        tick();
        cmp("lit_sq_rf_waddr", 32'(rf_waddr), 32'd9);
        cmp("lit_sq_rf_wdata", rf_wdata,      32'h2);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        cmp("lit_sq_pop_rf_we", 32'(rf_we),     32'd0);
        cmp("lit_sq_pop_wdata", rf_wdata,       32'h2);
        cmp("lit_sq_pop_count", 32'(buf_count), 32'd0);

        // Starvation
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 5'd20, 32'(100 + i), (i == 0), 5'd11, 32'hC);
            tick();
            cmp("lit_starve_stall", 32'(stall_pipe), 32'(i == 8));
        end
        set_in(1'b1, 5'd20, 32'd109, 1'b0, 5'd0, 32'd0);
        tick();
        cmp("lit_drain_rf_we",    32'(rf_we),      32'd1);
        cmp("lit_drain_rf_waddr", 32'(rf_waddr),   32'd11);
        cmp("lit_drain_rf_wdata", rf_wdata,        32'hC);
        cmp("lit_drain_stall",    32'(stall_pipe), 32'd0);
        tick();
        cmp("lit_held_rf_waddr", 32'(rf_waddr), 32'd20);
        cmp("lit_held_rf_wdata", rf_wdata,      32'd109);

        // Full
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'd21, 32'(i), 1'b1, 5'(22 + i), 32'(256 + i));
            tick();
        end
        cmp("lit_full_count",    32'(buf_count), 32'd4);
        cmp("lit_full_lu_ready", 32'(lu_ready),  32'd0);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'h30);
        tick();
        cmp("lit_unfull_count",    32'(buf_count), 32'd3);
        cmp("lit_unfull_lu_ready", 32'(lu_ready),  32'd1);
        cmp("lit_unfull_rf_waddr", 32'(rf_waddr),  32'd22);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with occasional mid-operation reset
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            rand_in(((c / 500) % 2 == 1) ? 92 : 45);
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
